fl_dma_channel_arbiter: RTL
===========================

Name: fl_dma_channel_arbiter

Overview:
- Hardware-side scheduler that shares the single host DMA transmit channel between PORTS FrameLink input streams.
- Grants whole frames round-robin, forwards the granted frame with zero added latency, and tags it with its source port.
- Honours a channel-open control from the software-driven DMA layer and counts forwarded frames for the host.

Parameters:
- PORTS, 4, number of FrameLink requesters (2..16).
- DATA_WIDTH, 64, FrameLink data width in bits.
- REM_WIDTH, 3, width of DREM (log2 of DATA_WIDTH/8).
- PORT_WIDTH, 2, width of port tag (log2 PORTS, min 1).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- RX_DATA  in  PORTS*DATA_WIDTH  input data; port i occupies slice i.
- RX_REM  in  PORTS*REM_WIDTH  input DREM per port.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  PORTS each  frame/part delimiters, active-low.
- RX_SRC_RDY_N  in  PORTS  source ready, active-low.
- RX_DST_RDY_N  out  PORTS  destination ready, active-low.
- TX_DATA  out  DATA_WIDTH  output data.
- TX_REM  out  REM_WIDTH  output DREM.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  output delimiters.
- TX_SRC_RDY_N  out  1  output source ready.
- TX_DST_RDY_N  in  1  DMA channel ready.
- TX_PORT  out  PORT_WIDTH  index of the granted port, valid while TX_SRC_RDY_N=0.
- CH_OPEN  in  1  1 = channel open; new grants allowed.
- CH_ACTIVE  out  1  1 while a frame is in flight.
- CNT_CLR  in  1  synchronous clear of PKT_CNT.
- PKT_CNT  out  32  completed frames since reset or clear.
- ERR_SOF  out  1  sticky flag: a requester presented a non-SOF beat while idle.

Behaviour:
- Reset: FSM=IDLE, grant=0, last=PORTS-1, PKT_CNT=0, ERR_SOF=0, CH_ACTIVE=0, all RX_DST_RDY_N=1, TX_SRC_RDY_N=1, TX_PORT=0.
- Request: port i requests when RX_SRC_RDY_N[i]=0 and RX_SOF_N[i]=0.
- IDLE:
  - If CH_OPEN=1 and any request, select the first requesting port scanning last+1, last+2, ... (mod PORTS).
  - Register grant and last=grant; go to XFER next cycle. This is a one-cycle arbitration bubble.
  - No RX_DST_RDY_N is asserted in IDLE.
- XFER:
  - Combinational pass-through: TX_* = RX_*[grant], TX_PORT = grant, RX_DST_RDY_N[grant] = TX_DST_RDY_N. Other ports hold RX_DST_RDY_N=1.
  - A beat transfers when RX_SRC_RDY_N[grant]=0 and TX_DST_RDY_N=0.
  - Frame end is a transferred beat with RX_EOF_N[grant]=0. On frame end: PKT_CNT += 1 (wraps 2^32-1 -> 0), return to IDLE.
  - A single-beat frame (SOF and EOF on the same beat) is legal and completes in one XFER cycle.
- CH_ACTIVE=1 exactly in XFER.
- Close: CH_OPEN dropping during XFER does not abort. The current frame completes, then the arbiter stays in IDLE until CH_OPEN=1.
- Simultaneous CNT_CLR and frame end: PKT_CNT becomes 0 (clear wins).
- ERR_SOF:
  - Set in IDLE when CH_OPEN=1 and some port has RX_SRC_RDY_N=0 and RX_SOF_N=0 is false for it (mid-frame beat).
  - That port is not granted. ERR_SOF is cleared only by reset.
- Source stalls (RX_SRC_RDY_N=1 in XFER) hold the grant indefinitely; there is no timeout.
- Reset mid-frame: immediate return to reset state. The partial frame is truncated and the downstream side must tolerate it.

Test Plan:
- Ports 0 and 2 each send a 3-beat frame while port 2 requests in the same cycle -> port 0 is granted first (last=3 after reset), then port 2; TX_PORT reads 0,0,0,2,2,2 with one idle cycle between frames; PKT_CNT=2.
- All 4 ports request continuously with 1-beat frames -> grant order 0,1,2,3,0; each frame is followed by one IDLE cycle; PKT_CNT=5 after 10 cycles.
- During a 4-beat frame from port 1, TX_DST_RDY_N=1 for 3 cycles at beat 2 -> RX_DST_RDY_N[1]=1 for those 3 cycles; data is unchanged at TX; frame ends after 7 XFER cycles.
- CH_OPEN drops at beat 2 of a 5-beat frame while port 3 requests -> frame completes, CH_ACTIVE falls, port 3 is not granted until CH_OPEN=1, then granted one cycle later.
- Port 0 asserts SRC_RDY with SOF_N=1 while idle -> ERR_SOF=1 and stays 1; port 0 is not granted.
- PKT_CNT preloaded to 0xFFFFFFFF via 2^32-1 frames (forced) plus one frame -> 0. CNT_CLR on the EOF beat -> 0.
- RESET_N pulsed low mid-frame -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fl_dma_channel_arbiter_if.sv
// FrameLink bundle between the PORTS requesters
// and the single DMA transmit channel.
interface fl_dma_channel_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int REM_WIDTH  = 3,
  parameter int PORT_WIDTH = 2
);
  logic [PORTS*DATA_WIDTH-1:0] RX_DATA;
  logic [PORTS*REM_WIDTH-1:0]  RX_REM;
  logic [PORTS-1:0]            RX_SOF_N;
  logic [PORTS-1:0]            RX_EOF_N;
  logic [PORTS-1:0]            RX_SOP_N;
  logic [PORTS-1:0]            RX_EOP_N;
  logic [PORTS-1:0]            RX_SRC_RDY_N;
  logic [PORTS-1:0]            RX_DST_RDY_N;
  logic [DATA_WIDTH-1:0]       TX_DATA;
  logic [REM_WIDTH-1:0]        TX_REM;
  logic                        TX_SOF_N;
  logic                        TX_EOF_N;
  logic                        TX_SOP_N;
  logic                        TX_EOP_N;
  logic                        TX_SRC_RDY_N;
  logic                        TX_DST_RDY_N;
  logic [PORT_WIDTH-1:0]       TX_PORT;

  modport slave (
    input  RX_DATA, RX_REM,
    input  RX_SOF_N, RX_EOF_N,
    input  RX_SOP_N, RX_EOP_N,
    input  RX_SRC_RDY_N,
    output RX_DST_RDY_N,
    output TX_DATA, TX_REM,
    output TX_SOF_N, TX_EOF_N,
    output TX_SOP_N, TX_EOP_N,
    output TX_SRC_RDY_N,
    input  TX_DST_RDY_N,
    output TX_PORT
  );

  modport master (
    output RX_DATA, RX_REM,
    output RX_SOF_N, RX_EOF_N,
    output RX_SOP_N, RX_EOP_N,
    output RX_SRC_RDY_N,
    input  RX_DST_RDY_N,
    input  TX_DATA, TX_REM,
    input  TX_SOF_N, TX_EOF_N,
    input  TX_SOP_N, TX_EOP_N,
    input  TX_SRC_RDY_N,
    output TX_DST_RDY_N,
    input  TX_PORT
  );
endinterface

// File: rtl/fl_dma_channel_arbiter.sv
// Round-robin whole-frame arbiter sharing one DMA
// transmit channel between PORTS FrameLink inputs.
module fl_dma_channel_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int REM_WIDTH  = 3,
  parameter int PORT_WIDTH = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  fl_dma_channel_arbiter_if.slave fl,
  input  logic        CH_OPEN,
  output logic        CH_ACTIVE,
  input  logic        CNT_CLR,
  output logic [31:0] PKT_CNT,
  output logic        ERR_SOF
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [PORT_WIDTH-1:0] grant_q, grant_d;
  logic [PORT_WIDTH-1:0] last_q, last_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [PORTS-1:0]      req;
  logic [PORTS-1:0]      bad;
  logic [PORT_WIDTH-1:0] pick;
  logic                  found;
  logic                  xfer;
  logic                  g_src_n;
  logic                  g_eof_n;
  logic                  frame_end;

  assign req  = ~fl.RX_SRC_RDY_N & ~fl.RX_SOF_N;
  assign bad  = ~fl.RX_SRC_RDY_N & fl.RX_SOF_N;
  assign xfer = (state_q == XFER);

  assign g_src_n = fl.RX_SRC_RDY_N[grant_q];
  assign g_eof_n = fl.RX_EOF_N[grant_q];

  assign frame_end = xfer & ~g_src_n
                   & ~fl.TX_DST_RDY_N & ~g_eof_n;

  // First requester after the last grant wins.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(last_q) + k) % PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PORT_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (CH_OPEN && |bad)
          err_d = 1'b1;
        if (CH_OPEN && found) begin
          state_d = XFER;
          grant_d = pick;
          last_d  = pick;
        end
      end
      (state_q == XFER): begin
        if (frame_end)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a coincident frame completion.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR)
      cnt_d = '0;
    else if (frame_end)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PORT_WIDTH'(PORTS - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fl.RX_DST_RDY_N = '1;
    if (xfer)
      fl.RX_DST_RDY_N[grant_q] = fl.TX_DST_RDY_N;
  end

  assign fl.TX_DATA =
    fl.RX_DATA[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign fl.TX_REM =
    fl.RX_REM[grant_q*REM_WIDTH +: REM_WIDTH];

  assign fl.TX_SRC_RDY_N = xfer ? g_src_n : 1'b1;
  assign fl.TX_SOF_N =
    xfer ? fl.RX_SOF_N[grant_q] : 1'b1;
  assign fl.TX_EOF_N = xfer ? g_eof_n : 1'b1;
  assign fl.TX_SOP_N =
    xfer ? fl.RX_SOP_N[grant_q] : 1'b1;
  assign fl.TX_EOP_N =
    xfer ? fl.RX_EOP_N[grant_q] : 1'b1;
  assign fl.TX_PORT = grant_q;

  assign CH_ACTIVE = xfer;
  assign PKT_CNT   = cnt_q;
  assign ERR_SOF   = err_q;

endmodule
